// File: rtl/pcw_mem_arbiter.sv
// Slot-timed arbiter: CPU, video, FDC DMA and refresh sharing one memory port.
// Define PCW_MEM_ARB_TIMEOUT_EN to build in the BUSY watchdog.
module pcw_mem_arbiter #(
   parameter int ADDR_W         = 19,
   parameter int REFRESH_FRAMES = 64,
   parameter int TIMEOUT_CLKS   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_sync,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [7:0]        vid_rdata,
   output logic              vid_ack,
   input  logic              fdc_req,
   input  logic              fdc_we,
   input  logic [ADDR_W-1:0] fdc_addr,
   input  logic [7:0]        fdc_wdata,
   output logic [7:0]        fdc_rdata,
   output logic              fdc_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_refresh,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              timeout_err
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_BUSY = 1'b1;

   localparam logic [1:0] O_CPU = 2'd0;
   localparam logic [1:0] O_VID = 2'd1;
   localparam logic [1:0] O_FDC = 2'd2;
   localparam logic [1:0] O_REF = 2'd3;

   localparam logic [7:0] FRM_LAST = 8'(REFRESH_FRAMES - 1);

   logic              state_q, state_d;
   logic [3:0]        slot_q;
   logic              synced_q;
   logic [7:0]        frm_q;
   logic              pend_q, pend_d;
   logic [1:0]        owner_q, owner_d;
   logic              we_q, we_d;
   logic              ref_q, ref_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        cpu_rd_q, cpu_rd_d;
   logic [7:0]        vid_rd_q, vid_rd_d;
   logic [7:0]        fdc_rd_q, fdc_rd_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              vid_ack_q, vid_ack_d;
   logic              fdc_ack_q, fdc_ack_d;

   logic gnt_a, gnt_b;
   logic cpu_el, vid_el, fdc_el;
   logic win_cpu, win_vid, win_fdc, win_ref;
   logic done, keep_rd;
   logic [7:0] done_data;

`ifdef PCW_MEM_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 1);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            to_q, to_d;
`endif

   assign gnt_a = frame_sync;
   assign gnt_b = synced_q && (slot_q == 4'd8) && !frame_sync;

   // an ack still showing means the request line is stale
   assign cpu_el = cpu_req && !cpu_ack_q;
   assign vid_el = vid_req && !vid_ack_q;
   assign fdc_el = fdc_req && !fdc_ack_q;

   always_comb begin
      win_cpu = 1'b0;
      win_vid = 1'b0;
      win_fdc = 1'b0;
      win_ref = 1'b0;
      if (state_q == S_IDLE) begin
         if (gnt_a) begin
            if (pend_q)      win_ref = 1'b1;
            else if (cpu_el) win_cpu = 1'b1;
            else if (fdc_el) win_fdc = 1'b1;
            else if (vid_el) win_vid = 1'b1;
         end else if (gnt_b) begin
            if (vid_el)      win_vid = 1'b1;
            else if (fdc_el) win_fdc = 1'b1;
            else if (cpu_el) win_cpu = 1'b1;
            else if (pend_q) win_ref = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      we_d      = we_q;
      ref_d     = ref_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cpu_rd_d  = cpu_rd_q;
      vid_rd_d  = vid_rd_q;
      fdc_rd_d  = fdc_rd_q;
      cpu_ack_d = 1'b0;
      vid_ack_d = 1'b0;
      fdc_ack_d = 1'b0;
      done      = 1'b0;
      done_data = mem_rdata;
      keep_rd   = we_q;
`ifdef PCW_MEM_ARB_TIMEOUT_EN
      wd_d      = wd_q;
      to_d      = to_q;
`endif
      pend_d = pend_q;
      if (win_ref)
         pend_d = 1'b0;
      if (frame_sync && (frm_q == FRM_LAST))
         pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (win_ref || win_cpu || win_fdc || win_vid) begin
               state_d = S_BUSY;
               we_d    = 1'b0;
               ref_d   = 1'b0;
               addr_d  = '0;
               wdata_d = '0;
`ifdef PCW_MEM_ARB_TIMEOUT_EN
               wd_d    = '0;
`endif
               if (win_ref) begin
                  owner_d = O_REF;
                  ref_d   = 1'b1;
               end else if (win_cpu) begin
                  owner_d = O_CPU;
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
               end else if (win_fdc) begin
                  owner_d = O_FDC;
                  we_d    = fdc_we;
                  addr_d  = fdc_addr;
                  wdata_d = fdc_wdata;
               end else begin
                  owner_d = O_VID;
                  addr_d  = vid_addr;
               end
            end
         end
         default: begin
            if (mem_ack) begin
               done = 1'b1;
`ifdef PCW_MEM_ARB_TIMEOUT_EN
            end else if (wd_q == WD_LAST) begin
               done      = 1'b1;
               done_data = 8'hFF;
               keep_rd   = 1'b0;
               to_d      = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
`endif
            end
            if (done) begin
               state_d = S_IDLE;
               case (owner_q)
                  O_CPU: begin
                     cpu_ack_d = 1'b1;
                     if (!keep_rd) cpu_rd_d = done_data;
                  end
                  O_VID: begin
                     vid_ack_d = 1'b1;
                     if (!keep_rd) vid_rd_d = done_data;
                  end
                  O_FDC: begin
                     fdc_ack_d = 1'b1;
                     if (!keep_rd) fdc_rd_d = done_data;
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q   <= '0;
         synced_q <= 1'b0;
         frm_q    <= '0;
      end else if (frame_sync) begin
         slot_q   <= 4'd1;
         synced_q <= 1'b1;
         frm_q    <= (frm_q == FRM_LAST) ? 8'd0 : frm_q + 8'd1;
      end else begin
         slot_q   <= slot_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pend_q    <= 1'b0;
         owner_q   <= O_CPU;
         we_q      <= 1'b0;
         ref_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cpu_rd_q  <= '0;
         vid_rd_q  <= '0;
         fdc_rd_q  <= '0;
         cpu_ack_q <= 1'b0;
         vid_ack_q <= 1'b0;
         fdc_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         ref_q     <= ref_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cpu_rd_q  <= cpu_rd_d;
         vid_rd_q  <= vid_rd_d;
         fdc_rd_q  <= fdc_rd_d;
         cpu_ack_q <= cpu_ack_d;
         vid_ack_q <= vid_ack_d;
         fdc_ack_q <= fdc_ack_d;
      end
   end

`ifdef PCW_MEM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_q <= '0;
         to_q <= 1'b0;
      end else begin
         wd_q <= wd_d;
         to_q <= to_d;
      end
   end

   assign timeout_err = to_q;
`else
   // watchdog absent: flag is constant low
   assign timeout_err = (TIMEOUT_CLKS < 0);
`endif

   assign mem_req     = state_q;
   assign mem_we      = we_q;
   assign mem_refresh = ref_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign cpu_rdata   = cpu_rd_q;
   assign vid_rdata   = vid_rd_q;
   assign fdc_rdata   = fdc_rd_q;
   assign cpu_ack     = cpu_ack_q;
   assign vid_ack     = vid_ack_q;
   assign fdc_ack     = fdc_ack_q;

endmodule

// File: tb/tb_pcw_mem_arbiter.sv
// Directed bench for pcw_mem_arbiter with a small timed memory model.
// Watchdog checks run only when PCW_MEM_ARB_TIMEOUT_EN is defined.
module tb_pcw_mem_arbiter;

   localparam int AW = 19;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_sync;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata, cpu_rdata;
   logic          cpu_ack;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [7:0]    vid_rdata;
   logic          vid_ack;
   logic          fdc_req, fdc_we;
   logic [AW-1:0] fdc_addr;
   logic [7:0]    fdc_wdata, fdc_rdata;
   logic          fdc_ack;
   logic          mem_req, mem_we, mem_refresh;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_ack;
   logic [7:0]    mem_rdata;
   logic          timeout_err;

   pcw_mem_arbiter #(.ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .frame_sync(frame_sync),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_rdata(vid_rdata), .vid_ack(vid_ack),
      .fdc_req(fdc_req), .fdc_we(fdc_we), .fdc_addr(fdc_addr),
      .fdc_wdata(fdc_wdata), .fdc_rdata(fdc_rdata), .fdc_ack(fdc_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_refresh(mem_refresh),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0, phase = 0, nsync = 0, mcnt = 0, ack_dly = 2;
   logic fs_en = 1'b0, inj_ack = 1'b0, prev_req = 1'b0, rise = 1'b0;
   logic [7:0] rd_key = 8'h00;

   int t0, nr, highs, acks, sr, nref, ref_at, refbad;
   int rc [4];
   logic [AW-1:0] ra [4];
   logic rw [4];
   logic [7:0] rwd [4];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock; inputs for the new cycle are applied 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      phase = (phase + 1) % 16;
      frame_sync = fs_en && (phase == 0);
      if (frame_sync) nsync++;
      if (mem_req) mcnt++;
      else mcnt = 0;
      mem_ack = inj_ack || (mem_req && ack_dly != 0 && mcnt == ack_dly);
      mem_rdata = mem_addr[7:0] ^ rd_key;
      rise = mem_req && !prev_req;
      prev_req = mem_req;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      fs_en = 1'b0; frame_sync = 1'b0; inj_ack = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      vid_req = 0; vid_addr = '0;
      fdc_req = 0; fdc_we = 0; fdc_addr = '0; fdc_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
      ack_dly = 2; rd_key = 8'h00; nsync = 0; mcnt = 0; prev_req = 0;
      @(posedge clk);
      #1;
      check("rst_ctl", {mem_req, mem_we, mem_refresh, cpu_ack,
                        vid_ack, fdc_ack, timeout_err}, 0);
      check("rst_addr", {mem_addr, mem_wdata}, 0);
      check("rst_rdata", {cpu_rdata, vid_rdata, fdc_rdata}, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      phase = 13;
   endtask

   task automatic wait_sync(output int t);
      for (int i = 0; i < 40 && !frame_sync; i++) step();
      check("sync_seen", frame_sync, 1);
      t = cyc;
   endtask

   initial begin
      reset = 1'b1;

      // no grant without frame_sync
      do_reset();
      cpu_req = 1; cpu_addr = 19'h00042;
      highs = 0; acks = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         highs += int'(mem_req);
         acks += int'(cpu_ack);
      end
      check("nosync_req", highs, 0);
      check("nosync_ack", acks, 0);

      // CPU read with memory acking on the second mem_req cycle
      do_reset();
      fs_en = 1; cpu_req = 1; cpu_we = 0;
      cpu_addr = 19'h01234; rd_key = 8'h91;
      wait_sync(t0);
      check("rd_req_T", mem_req, 0);
      step();
      check("rd_req_T1", mem_req, 1);
      check("rd_addr", mem_addr, 19'h01234);
      check("rd_we", {mem_we, mem_refresh}, 0);
      step();
      check("rd_req_T2", mem_req, 1);
      check("rd_ack_T2", cpu_ack, 0);
      step();
      check("rd_req_T3", mem_req, 0);
      check("rd_ack_T3", cpu_ack, 1);
      check("rd_data", cpu_rdata, 8'hA5);
      cpu_req = 0;
      step();
      check("rd_ack_T4", cpu_ack, 0);
      check("rd_hold", cpu_rdata, 8'hA5);

      // point A priority then B then A
      do_reset();
      fs_en = 1;
      cpu_req = 1; cpu_addr = 19'h10011;
      vid_req = 1; vid_addr = 19'h20022;
      fdc_req = 1; fdc_we = 1; fdc_addr = 19'h30033; fdc_wdata = 8'h3C;
      wait_sync(t0);
      nr = 0;
      for (int i = 0; i < 24; i++) begin
         step();
         if (rise) begin
            if (nr < 4) begin
               rc[nr] = cyc - t0; ra[nr] = mem_addr;
               rw[nr] = mem_we; rwd[nr] = mem_wdata;
            end
            nr++;
         end
         if (cpu_ack) cpu_req = 0;
         if (vid_ack) vid_req = 0;
         if (fdc_ack) fdc_req = 0;
      end
      check("pri_count", nr, 3);
      if (nr >= 3) begin
         check("pri_t0", rc[0], 1);
         check("pri_a0", ra[0], 19'h10011);
         check("pri_t1", rc[1], 9);
         check("pri_a1", ra[1], 19'h20022);
         check("pri_we1", rw[1], 0);
         check("pri_t2", rc[2], 17);
         check("pri_a2", ra[2], 19'h30033);
         check("pri_we2", {rw[2], rwd[2]}, {1'b1, 8'h3C});
      end
      check("pri_cpu_rd", cpu_rdata, 8'h11);
      check("pri_vid_rd", vid_rdata, 8'h22);
      check("pri_fdc_rd", fdc_rdata, 8'h00);

      // slow memory: B inside the access is skipped
      do_reset();
      fs_en = 1; ack_dly = 12;
      vid_req = 1; vid_addr = 19'h00777;
      wait_sync(t0);
      nr = 0; highs = 0; acks = 0; sr = -1;
      for (int i = 0; i < 18; i++) begin
         step();
         if (rise) begin
            if (nr == 1) sr = cyc - t0;
            nr++;
         end
         if (cyc - t0 <= 13) highs += int'(mem_req);
         acks += int'(vid_ack);
      end
      check("slow_rises", nr, 2);
      check("slow_next", sr, 17);
      check("slow_len", highs, 12);
      check("slow_acks", acks, 1);
      check("slow_rd", vid_rdata, 8'h77);

      // mem_ack while idle is ignored
      do_reset();
      fs_en = 1;
      wait_sync(t0);
      acks = 0; highs = 0;
      for (int i = 0; i < 6; i++) begin
         inj_ack = (i == 1);
         step();
         acks += int'(cpu_ack) + int'(vid_ack) + int'(fdc_ack);
         highs += int'(mem_req);
      end
      inj_ack = 0;
      check("idle_ack", acks, 0);
      check("idle_req", highs, 0);

      // reset in the middle of an access
      do_reset();
      fs_en = 1; ack_dly = 0;
      cpu_req = 1; cpu_addr = 19'h00055;
      wait_sync(t0);
      step();
      step();
      check("mid_busy", mem_req, 1);
      #2 reset = 1'b1;
      #1 check("mid_async", mem_req, 0);
      @(posedge clk);
      #1;
      reset = 1'b0; cpu_req = 0; fs_en = 0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         acks += int'(cpu_ack);
      end
      check("mid_noack", acks, 0);

      // refresh every REFRESH_FRAMES frames with CPU writes held
      do_reset();
      fs_en = 1; ack_dly = 2;
      cpu_req = 1; cpu_we = 1; cpu_addr = 19'h04444; cpu_wdata = 8'h99;
      nr = 0; nref = 0; ref_at = -1; refbad = 0; acks = 0;
      for (int i = 0; i < 2000 && nsync < 67; i++) begin
         step();
         if (nsync < 67) begin
            if (rise) begin
               nr++;
               if (mem_refresh) begin
                  nref++;
                  ref_at = nsync;
                  if (mem_addr != '0 || mem_we) refbad++;
               end
            end
            acks += int'(cpu_ack);
         end
      end
      check("ref_done", nsync, 67);
      check("ref_count", nref, 1);
      check("ref_frame", ref_at, 65);
      check("ref_cmd", refbad, 0);
      check("ref_grants", nr, 132);
      check("ref_cpu_acks", acks, 131);
      check("ref_wr_rd", cpu_rdata, 8'h00);
      cpu_req = 0;

`ifdef PCW_MEM_ARB_TIMEOUT_EN
      do_reset();
      fs_en = 1; ack_dly = 0;
      fdc_req = 1; fdc_we = 0; fdc_addr = 19'h00100;
      wait_sync(t0);
      highs = 0; acks = 0; sr = -1;
      for (int i = 0; i < 40; i++) begin
         step();
         highs += int'(mem_req);
         if (fdc_ack) begin
            acks++;
            sr = cyc - t0;
            fdc_req = 0;
            check("wd_data", fdc_rdata, 8'hFF);
         end
      end
      check("wd_len", highs, 32);
      check("wd_acks", acks, 1);
      check("wd_at", sr, 33);
      check("wd_err", timeout_err, 1);
      do_reset();
      check("wd_err_clr", timeout_err, 0);
`else
      check("no_wd_err", timeout_err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
